// File: rtl/dual_port_ram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dual_port_ram_ctrl                                            |
// | Purpose  : True dual-port RAM with post-reset clear, valid/ready ports,  |
// |            registered reads and port-A-wins write collision handling.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dual_port_ram_ctrl #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   input  logic                  a_wr,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ready,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  a_rvalid,
   input  logic                  b_valid,
   input  logic                  b_wr,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ready,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  b_rvalid,
   output logic                  init_done,
   output logic                  collision,
   output logic [7:0]            coll_cnt
);

   localparam int                    c_DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
   logic [DATA_WIDTH-1:0]   r_a_rdata;
   logic [DATA_WIDTH-1:0]   r_b_rdata;
   logic                    r_a_rvalid;
   logic                    r_b_rvalid;
   logic                    r_collision;
   logic [7:0]              r_coll_cnt;

   logic w_run;
   logic w_a_we;
   logic w_a_re;
   logic w_b_we;
   logic w_b_re;
   logic w_wcoll;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_INIT) begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      if ((r_state == ST_INIT) && (r_ptr == c_LAST_ADDR)) begin
         w_state_next = ST_RUN;
      end
   end

   assign w_run   = (r_state == ST_RUN);
   assign w_a_we  = w_run & a_valid & a_wr;
   assign w_a_re  = w_run & a_valid & ~a_wr;
   assign w_b_we  = w_run & b_valid & b_wr;
   assign w_b_re  = w_run & b_valid & ~b_wr;
   assign w_wcoll = w_a_we & w_b_we & (a_addr == b_addr);

   // Port A is written last so it wins a same-address write-write.
   always_ff @(posedge clk) begin
      if (!w_run) begin
         r_mem[r_ptr] <= INIT_VALUE;
      end else begin
         if (w_b_we && !w_wcoll) begin
            r_mem[b_addr] <= b_wdata;
         end
         if (w_a_we) begin
            r_mem[a_addr] <= a_wdata;
         end
      end
   end

   // Reads sample the pre-edge array contents, giving read-first behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_rdata   <= '0;
         r_b_rdata   <= '0;
         r_a_rvalid  <= 1'b0;
         r_b_rvalid  <= 1'b0;
         r_collision <= 1'b0;
         r_coll_cnt  <= '0;
      end else begin
         r_a_rvalid  <= w_a_re;
         r_b_rvalid  <= w_b_re;
         r_collision <= w_wcoll;
         if (w_a_re) begin
            r_a_rdata <= r_mem[a_addr];
         end
         if (w_b_re) begin
            r_b_rdata <= r_mem[b_addr];
         end
         if (w_wcoll && (r_coll_cnt != 8'hFF)) begin
            r_coll_cnt <= r_coll_cnt + 8'd1;
         end
      end
   end

   assign a_ready   = w_run;
   assign b_ready   = w_run;
   assign init_done = w_run;
   assign a_rdata   = r_a_rdata;
   assign b_rdata   = r_b_rdata;
   assign a_rvalid  = r_a_rvalid;
   assign b_rvalid  = r_b_rvalid;
   assign collision = r_collision;
   assign coll_cnt  = r_coll_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dual_port_ram_ctrl                                         |
// | Purpose  : Self-checking bench for dual_port_ram_ctrl against a model.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dual_port_ram_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0, a_wr = 1'b0, b_valid = 1'b0, b_wr = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_ready, b_ready, a_rvalid, b_rvalid, init_done, collision;
   logic [DW-1:0] a_rdata, b_rdata;
   logic [7:0]    coll_cnt;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [DW-1:0] m_mem [DEPTH];
   int            m_init = 0;
   int            e_cnt = 0;
   logic          e_ready = 1'b0, e_a_rvalid = 1'b0, e_b_rvalid = 1'b0, e_coll = 1'b0;
   logic [DW-1:0] e_a_rdata = '0, e_b_rdata = '0;

   always #5 clk = ~clk;

   dual_port_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_valid(b_valid), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .init_done(init_done), .collision(collision), .coll_cnt(coll_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_init = 0;
      e_cnt = 0;
      e_ready = 0; e_a_rvalid = 0; e_b_rvalid = 0; e_coll = 0;
      e_a_rdata = '0; e_b_rdata = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
   endtask

   task automatic model_step();
      e_a_rvalid = 0; e_b_rvalid = 0; e_coll = 0;
      if (m_init < DEPTH) begin
         m_init++;
      end else begin
         if (a_valid && !a_wr) begin e_a_rvalid = 1; e_a_rdata = m_mem[a_addr]; end
         if (b_valid && !b_wr) begin e_b_rvalid = 1; e_b_rdata = m_mem[b_addr]; end
         if (a_valid && a_wr && b_valid && b_wr && a_addr == b_addr) begin
            e_coll = 1;
            if (e_cnt < 255) e_cnt++;
         end
         if (b_valid && b_wr) m_mem[b_addr] = b_wdata;
         if (a_valid && a_wr) m_mem[a_addr] = a_wdata;
      end
      e_ready = (m_init == DEPTH);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(negedge clk);
         check("a_ready",   a_ready,   e_ready);
         check("b_ready",   b_ready,   e_ready);
         check("init_done", init_done, e_ready);
         check("a_rvalid",  a_rvalid,  e_a_rvalid);
         check("b_rvalid",  b_rvalid,  e_b_rvalid);
         check("a_rdata",   a_rdata,   e_a_rdata);
         check("b_rdata",   b_rdata,   e_b_rdata);
         check("collision", collision, e_coll);
         check("coll_cnt",  coll_cnt,  e_cnt);
      end
   end

   task automatic drive(input logic av, input logic aw, input int aa, input int ad,
                        input logic bv, input logic bw, input int ba, input int bd);
      a_valid = av; a_wr = aw; a_addr = AW'(aa); a_wdata = DW'(ad);
      b_valid = bv; b_wr = bw; b_addr = AW'(ba); b_wdata = DW'(bd);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      // requests during INIT must be ignored
      drive(1, 1, 4, 8'hEE, 1, 1, 9, 8'hEE);
      n = 0;
      while (1) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (a_ready || n >= 100) break;
      end
      idle();
      check("init_len", n, 16);
      cyc();

      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, i, 0, 0, 0, 0, 0);
         cyc();
         check("init_rvalid", a_rvalid, 1);
         check("init_rdata", a_rdata, 8'h00);
      end

      drive(1, 1, 3, 8'h5A, 0, 0, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 1, 0, 3, 0);
      cyc();
      check("basic_rvalid", b_rvalid, 1);
      check("basic_rdata", b_rdata, 8'h5A);

      drive(1, 1, 7, 8'h11, 1, 1, 7, 8'h22);
      cyc();
      check("ww_pulse", collision, 1);
      check("ww_cnt", coll_cnt, 1);
      drive(1, 0, 7, 0, 0, 0, 0, 0);
      cyc();
      check("ww_pulse_end", collision, 0);
      check("ww_winner", a_rdata, 8'h11);

      drive(1, 1, 9, 8'hAA, 0, 0, 0, 0);
      cyc();
      drive(1, 1, 9, 8'hBB, 1, 0, 9, 0);
      cyc();
      check("rdw_old", b_rdata, 8'hAA);
      drive(1, 0, 9, 0, 0, 0, 0, 0);
      cyc();
      check("rdw_new", a_rdata, 8'hBB);

      for (int i = 0; i < 300; i++) begin
         drive(1, 1, 5, i, 1, 1, 5, ~i);
         cyc();
      end
      check("sat_cnt", coll_cnt, 255);
      idle();
      cyc();
      check("sat_hold", coll_cnt, 255);

      for (int i = 0; i < 800; i++) begin
         int ra, rb;
         ra = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         rb = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), ra, $urandom_range(0, 255),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1), rb, $urandom_range(0, 255));
         cyc();
      end

      drive(1, 1, 2, 8'hFF, 0, 0, 0, 0);
      cyc();
      drive(1, 0, 2, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      check("rst_rvalid", a_rvalid, 0);
      check("rst_cnt", coll_cnt, 0);
      repeat (15) cyc();
      check("reinit_busy", a_ready, 0);
      cyc();
      check("reinit_ready", a_ready, 1);
      drive(1, 0, 2, 0, 0, 0, 0, 0);
      cyc();
      check("reinit_rvalid", a_rvalid, 1);
      check("reinit_rdata", a_rdata, 8'h00);
      idle();
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
